// File: rtl/axi_frame_packer.sv
// Packs PACK_RATIO narrow samples per wide word (first sample in LSBs), tags frame ends with tlast,
// and only starts a frame while the downstream FIFO is not almost full. Optional flush: PACKER_FLUSH_EN.
`timescale 1ns/1ps
module axi_frame_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int PACK_RATIO = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]            s_axis_tdata,
  output logic                           s_axis_tready,
  input  logic [CNT_WIDTH-1:0]           frame_len,
  input  logic                           fifo_almost_full,
`ifdef PACKER_FLUSH_EN
  input  logic                           flush,
`endif
  output logic                           m_axis_tvalid,
  output logic [IN_WIDTH*PACK_RATIO-1:0] m_axis_tdata,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [CNT_WIDTH-1:0]           frame_count
);

  localparam int OUT_W  = IN_WIDTH * PACK_RATIO;
  localparam int LANE_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);

  typedef enum logic {HOLD, RUN} state_t;

  state_t               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [OUT_W-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           occ_q, occ_d;

  logic             tready_int, accept, push, push_last, pop, word_done;
  logic [OUT_W-1:0] asm_word, push_data;
  logic             flush_req;

`ifdef PACKER_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
  assign flush_req = flush || flush_pend_q;
`else
  assign flush_req = 1'b0;
`endif

  // Ready depends on registered state only, never on s_axis_tvalid.
  assign tready_int = (state_q == RUN) && (occ_q != 2'd2) && !flush_req;
  assign accept     = s_axis_tvalid && tready_int;
  assign word_done  = (word_cnt_q == (frame_len_q - CNT_WIDTH'(1)));
  assign pop        = (occ_q != 2'd0) && m_axis_tready;

  always_comb begin
    asm_word = acc_q;
    asm_word[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_cnt_d  = word_cnt_q;
    frame_len_d = frame_len_q;
    acc_d       = acc_q;
    push        = 1'b0;
    push_data   = asm_word;
    push_last   = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush_pend_d = flush_pend_q;
`endif
    case (state_q)
      HOLD: begin
        if (!fifo_almost_full) begin
          state_d     = RUN;
          frame_len_d = (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
        end
      end
      default: begin
        if (accept) begin
          if (lane_q == LAST_LANE) begin
            push       = 1'b1;
            push_last  = word_done;
            lane_d     = '0;
            acc_d      = '0;
            word_cnt_d = word_done ? '0 : word_cnt_q + CNT_WIDTH'(1);
            if (word_done) state_d = HOLD;
          end else begin
            lane_d = lane_q + LANE_W'(1);
            acc_d  = asm_word;
          end
        end
`ifdef PACKER_FLUSH_EN
        // Unused upper lanes of acc_q are already zero, so a partial word is zero-padded as is.
        if (flush_req) begin
          if ((lane_q != '0) || (word_cnt_q != '0)) begin
            if (occ_q != 2'd2) begin
              push         = 1'b1;
              push_data    = (lane_q != '0) ? acc_q : '0;
              push_last    = 1'b1;
              lane_d       = '0;
              word_cnt_d   = '0;
              acc_d        = '0;
              state_d      = HOLD;
              flush_pend_d = 1'b0;
            end else begin
              flush_pend_d = 1'b1;
            end
          end else begin
            lane_d       = '0;
            word_cnt_d   = '0;
            acc_d        = '0;
            state_d      = HOLD;
            flush_pend_d = 1'b0;
          end
        end
`endif
      end
    endcase
  end

  // Two-entry output skid; buf0 is always the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    last_d = last_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d    = push_data;
          last_d[0] = push_last;
        end else begin
          buf1_d    = push_data;
          last_d[1] = push_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = '0;
        last_d = {1'b0, last_q[1]};
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d    = push_data;
          last_d[0] = push_last;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_data;
          last_d = {push_last, last_q[1]};
        end
      end
      default: ;
    endcase
    frame_count_d = frame_count_q + CNT_WIDTH'(pop && last_q[0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HOLD;
      lane_q        <= '0;
      word_cnt_q    <= '0;
      frame_len_q   <= CNT_WIDTH'(1);
      frame_count_q <= '0;
      acc_q         <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      last_q        <= '0;
      occ_q         <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      word_cnt_q    <= word_cnt_d;
      frame_len_q   <= frame_len_d;
      frame_count_q <= frame_count_d;
      acc_q         <= acc_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      last_q        <= last_d;
      occ_q         <= occ_d;
    end
  end

`ifdef PACKER_FLUSH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flush_pend_q <= 1'b0;
    else          flush_pend_q <= flush_pend_d;
  end
`endif

  assign s_axis_tready = tready_int;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = buf0_q;
  assign m_axis_tlast  = last_q[0];
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axi_frame_packer.sv
// Directed bench for axi_frame_packer (IN_WIDTH=16, PACK_RATIO=2): packing, backpressure,
// almost_full at frame boundaries, frame_len changes, async reset, and flush when enabled.
`timescale 1ns/1ps
module tb_axi_frame_packer;

  logic        clk;
  logic        reset_n;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tready;
  logic [15:0] frame_len;
  logic        fifo_almost_full;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] frame_count;
`ifdef PACKER_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];

  axi_frame_packer #(.IN_WIDTH(16), .PACK_RATIO(2), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tready    (s_axis_tready),
    .frame_len        (frame_len),
    .fifo_almost_full (fifo_almost_full),
`ifdef PACKER_FLUSH_EN
    .flush            (flush),
`endif
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .frame_count      (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output words handshaking at the coming rising edge, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && m_axis_tvalid && m_axis_tready)
      out_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input int max_cyc, output int cyc);
    logic ok;
    ok  = 1'b0;
    cyc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (!ok && cyc < max_cyc) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    check($sformatf("accept_%0h", d), ok, 1'b1);
  endtask

  task automatic expw(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic check_out(input string tag);
    int n;
    check({tag, "_count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int c;
    reset_n          = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = '0;
    frame_len        = 16'd4;
    fifo_almost_full = 1'b0;
    m_axis_tready    = 1'b1;
`ifdef PACKER_FLUSH_EN
    flush            = 1'b0;
`endif
    tick(3);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    reset_n = 1'b1;

    // Basic frame of four words.
    for (int v = 1; v <= 8; v++) send(16'(v), 20, c);
    tick(5);
    expw(0, 32'h00020001); expw(0, 32'h00040003); expw(0, 32'h00060005); expw(1, 32'h00080007);
    check_out("basic");
    check("basic_frame_count", frame_count, 16'd1);

    // Downstream stall mid-frame.
    send(16'd9, 20, c);
    send(16'd10, 20, c);
    m_axis_tready = 1'b0;
    fork
      begin
        int c2;
        for (int v = 11; v <= 16; v++) send(16'(v), 60, c2);
      end
      begin
        tick(4);
        check("stall_head_early", m_axis_tdata, 32'h000A0009);
        tick(6);
        check("stall_s_tready", s_axis_tready, 1'b0);
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_head_late", m_axis_tdata, 32'h000A0009);
        check("stall_tlast", m_axis_tlast, 1'b0);
        m_axis_tready = 1'b1;
      end
    join
    tick(6);
    expw(0, 32'h000A0009); expw(0, 32'h000C000B); expw(0, 32'h000E000D); expw(1, 32'h0010000F);
    check_out("stall");
    check("stall_frame_count", frame_count, 16'd2);

    // almost_full: ignored mid-frame, honoured at the boundary.
    for (int v = 17; v <= 20; v++) send(16'(v), 20, c);
    fifo_almost_full = 1'b1;
    for (int v = 21; v <= 24; v++) begin
      send(16'(v), 20, c);
      check($sformatf("af_mid_cycles_%0d", v), c, 1);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("af_hold_%0d", i), s_axis_tready, 1'b0);
      tick(1);
    end
    fifo_almost_full = 1'b0;
    check("af_fall_still_hold", s_axis_tready, 1'b0);
    tick(1);
    check("af_resume", s_axis_tready, 1'b1);
    tick(4);
    expw(0, 32'h00120011); expw(0, 32'h00140013); expw(0, 32'h00160015); expw(1, 32'h00180017);
    check_out("af");
    check("af_frame_count", frame_count, 16'd3);

    // frame_len changed mid-frame, then frame_len=0.
    for (int v = 1; v <= 4; v++) send(16'(v), 20, c);
    frame_len = 16'd2;
    for (int v = 5; v <= 12; v++) send(16'(v), 20, c);
    frame_len = 16'd0;
    for (int v = 13; v <= 16; v++) send(16'(v), 20, c);
    tick(4);
    expw(0, 32'h00020001); expw(0, 32'h00040003); expw(0, 32'h00060005); expw(1, 32'h00080007);
    expw(0, 32'h000A0009); expw(1, 32'h000C000B);
    expw(1, 32'h000E000D); expw(1, 32'h0010000F);
    check_out("flen");
    check("flen_frame_count", frame_count, 16'd7);

    // Asynchronous reset with a word buffered and a partial word pending.
    frame_len     = 16'd4;
    m_axis_tready = 1'b0;
    send(16'h0011, 20, c);
    send(16'h0022, 20, c);
    send(16'h0033, 20, c);
    check("pre_rst_tvalid", m_axis_tvalid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 1'b0);
    check("arst_tdata", m_axis_tdata, 32'h0);
    check("arst_tlast", m_axis_tlast, 1'b0);
    check("arst_s_tready", s_axis_tready, 1'b0);
    check("arst_frame_count", frame_count, 16'd0);
    tick(2);
    reset_n       = 1'b1;
    frame_len     = 16'd2;
    m_axis_tready = 1'b1;
    out_q.delete();
    for (int v = 'h41; v <= 'h44; v++) send(16'(v), 20, c);
    tick(4);
    expw(0, 32'h00420041); expw(1, 32'h00440043);
    check_out("post_rst");
    check("post_rst_frame_count", frame_count, 16'd1);

`ifdef PACKER_FLUSH_EN
    // Flush with a partial word pending.
    frame_len = 16'd4;
    tick(2);
    for (int v = 1; v <= 3; v++) send(16'(v), 20, c);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    expw(0, 32'h00020001); expw(1, 32'h00000003);
    check_out("flush");
    check("flush_frame_count", frame_count, 16'd2);
    for (int v = 5; v <= 8; v++) send(16'(v), 20, c);
    tick(4);
    expw(0, 32'h00060005); expw(0, 32'h00080007);
    check_out("post_flush");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_frame_packer.md
Name: axi_frame_packer

Overview:
- Sits directly upstream of the channelizer's AXI FIFO.
- Packs PACK_RATIO narrow input samples into one wide word, with the first sample in the LSBs.
- Asserts m_axis_tlast on the last word of every frame.
- At frame boundaries only, stalls while the downstream FIFO reports almost_full, so frames are never split by backpressure.

Parameters:
- IN_WIDTH, 16, width of one input sample.
- PACK_RATIO, 2, samples per output word; legal range 1..8.
- CNT_WIDTH, 16, width of the frame-length and frame-count fields.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  IN_WIDTH  input sample
- s_axis_tready  out  1  input accept
- frame_len  in  CNT_WIDTH  output words per frame; sampled at frame start
- fifo_almost_full  in  1  almost_full from the downstream FIFO
- m_axis_tvalid  out  1  packed word valid
- m_axis_tdata  out  IN_WIDTH*PACK_RATIO  packed word
- m_axis_tlast  out  1  last word of frame
- m_axis_tready  in  1  downstream accept
- frame_count  out  CNT_WIDTH  completed frames accepted downstream; wraps

Behaviour:
- Reset (async assert, synchronous release):
  - state=HOLD; lane=0; word_cnt=0; frame_len_q=1; frame_count=0.
  - Output buffer empty; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; s_axis_tready=0.
  - Reset mid-frame discards the partial word and all buffered words; no tlast is emitted for the aborted frame.
- State machine:
  - HOLD → RUN on the first cycle with fifo_almost_full=0. On that transition frame_len_q ← frame_len, except frame_len=0 is treated as 1.
  - RUN → HOLD in the cycle the final sample of a frame's last word is accepted. The next frame start re-checks almost_full.
  - fifo_almost_full is ignored inside RUN; it never splits a frame.
- s_axis_tready = (state==RUN) && (buffer occupancy < 2). It is combinational from registered state only and has no path from s_axis_tvalid.
- Accept = s_axis_tvalid && s_axis_tready.
  - On accept, sample goes to lane slot `lane`, occupying bits [lane*IN_WIDTH +: IN_WIDTH].
  - lane increments and wraps at PACK_RATIO-1.
- On accept with lane==PACK_RATIO-1, the completed word is pushed to the 2-entry output buffer:
  - tlast = (word_cnt==frame_len_q-1).
  - word_cnt increments, or clears to 0 when tlast is set.
  - Arithmetic is modulo 2^CNT_WIDTH.
- Output buffer: 2-entry register skid.
  - m_axis_tvalid = occupancy!=0. Head data and tlast are stable while tvalid=1 and tready=0.
  - Push and pop in the same cycle leave occupancy unchanged.
  - A push at occupancy 2 cannot occur, because tready gates it.
- Latency: one cycle from acceptance of a word's final sample to m_axis_tvalid=1 when the buffer is empty.
- Throughput: one input sample per cycle sustained while m_axis_tready=1 within a frame.
- Frame boundary cost: one HOLD cycle per frame boundary even when almost_full is low; throughput loss is 1 cycle per frame.
- frame_count increments when a word with tlast=1 is accepted downstream; wraps from 2^CNT_WIDTH-1 to 0.
- PACK_RATIO=1: every accepted sample is a complete word.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- When defined, adds input flush (1 bit, synchronous pulse). When flush=1 in RUN:
  - A partial word (lane≠0) is zero-padded and pushed with tlast=1.
  - If lane==0 and word_cnt≠0, the previously pushed word cannot be retagged; an all-zero word with tlast=1 is pushed instead.
  - If lane==0 and word_cnt==0, nothing is pushed.
  - lane and word_cnt clear; state → HOLD.
  - A sample accepted in the same cycle as flush is dropped; s_axis_tready is forced 0 that cycle.
  - A flush-initiated push waits until occupancy<2; flush is held pending until then.
- Not defined: no flush port, no pending logic.

Test Plan:
- IN_WIDTH=16, PACK_RATIO=2, frame_len=4, feed samples 1..8 continuously, m_axis_tready=1 → 4 words 0x00020001, 0x00040003, 0x00060005, 0x00080007; tlast only on the 4th; frame_count=1.
- Same setup, m_axis_tready=0 for 10 cycles mid-frame → s_axis_tready drops once occupancy=2; no words lost or duplicated; head word stable throughout the stall.
- fifo_almost_full=1 at frame boundary for 5 cycles → s_axis_tready=0 for those 5 cycles; next frame begins the cycle after almost_full falls. Also assert almost_full mid-frame → no stall.
- frame_len changed from 4 to 2 mid-frame → current frame still ends after 4 words; the next frame has tlast on its 2nd word. frame_len=0 → every word has tlast.
- reset_n pulsed low asynchronously mid-frame with 1 word buffered → outputs zero immediately; after release the first frame starts with lane 0 and word_cnt 0.
- PACKER_FLUSH_EN defined: 3 samples accepted (PACK_RATIO=2), then flush → second word 0x00000003 with tlast=1; lane=0 afterwards.
